// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller slice.
// Contents: FSM state type, default parameter values, and a helper that
// returns the lowest set bit index of a vector (fixed-priority arbitration).
package intr_pkg;

  localparam int unsigned NUM_SRC_DEF     = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned MAX_SRC         = 32;

  typedef enum logic [1:0] {IDLE, REQ, ACK} intr_state_t;

  // Lowest index wins; returns 0 when no bit is set (caller qualifies with |vec).
  function automatic logic [4:0] lowest_set(input logic [MAX_SRC-1:0] vec);
    logic [4:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_SRC; i++) begin
      if (vec[i] && !found) begin
        idx   = 5'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// INT/intTaken handshake between the interrupt controller and the CU.
//   INT       : request to the CU
//   int_id    : index of the requested source, valid while INT=1
//   int_taken : CU acknowledge, high for 2 cycles per trap entry
// modport master = controller side, modport slave = CU side.
interface intr_ctrl_if #(
  parameter int unsigned NUM_SRC = intr_pkg::NUM_SRC_DEF
);
  localparam int unsigned ID_W = $clog2(NUM_SRC);

  logic            INT;
  logic [ID_W-1:0] int_id;
  logic            int_taken;

  modport master (output INT, output int_id, input int_taken);
  modport slave  (input INT, input int_id, output int_taken);
endinterface

// File: rtl/intr_sync_edge.sv
// Multi-flop synchronizer plus rising-edge detector for a vector of
// asynchronous level inputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : asynchronous levels
//   rise       : one-cycle pulse per synchronized rising edge
module intr_sync_edge #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [STAGES-1:0][WIDTH-1:0] stage;
  logic [WIDTH-1:0]             prev;
  logic [WIDTH-1:0]             primed;
  logic [STAGES-1:0]            warm;
  logic [WIDTH-1:0]             sync_out;

  assign sync_out = stage[STAGES-1];

  // A source only becomes edge-capable once a low level has been seen at the
  // synchronizer output after the chain has refilled from reset (warm). This
  // keeps a source held high across reset from producing an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage  <= '0;
      prev   <= '0;
      primed <= '0;
      warm   <= '0;
    end else begin
      stage[0] <= din;
      for (int unsigned k = 1; k < STAGES; k++) begin
        stage[k] <= stage[k-1];
      end
      prev   <= sync_out;
      warm   <= {warm[STAGES-2:0], 1'b1};
      if (warm[STAGES-1]) begin
        primed <= primed | ~sync_out;
      end
    end
  end

  assign rise = sync_out & ~prev & primed;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches synchronized rising edges of irq_src as
// pending, applies an enable mask and the global MIE bit, and presents one
// fixed-priority (lowest index) request to the CU over the INT/intTaken
// handshake, retiring it exactly once per trap entry.
//   CLK, RST_N  : clock, asynchronous active-low reset
//   irq_src     : asynchronous source levels (rising edge = event)
//   mie         : global interrupt enable
//   mask_we     : mask write strobe, mask_wdata : new mask
//   pend_clr    : software clear pulses for pending bits
//   cu          : INT / int_id / int_taken handshake (master side)
//   pending     : pending register, mask : enable-mask register
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned NUM_SRC     = NUM_SRC_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mie,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic [NUM_SRC-1:0] pend_clr,
  intr_ctrl_if.master        cu,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  localparam int unsigned ID_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ack_vec;
  logic [MAX_SRC-1:0] elig_wide;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    id_d;
  intr_state_t        state_q;
  intr_state_t        state_d;
  logic               int_q;

  intr_sync_edge #(
    .WIDTH  (NUM_SRC),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .din   (irq_src),
    .rise  (rise)
  );

  assign eligible = pending & mask;

  always_comb begin
    elig_wide                = '0;
    elig_wide[NUM_SRC-1:0]   = eligible;
    win_id                   = ID_W'(lowest_set(elig_wide));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mask <= '0;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

  // Set dominates clear: a new edge in the same cycle as its ack survives.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~(pend_clr | ack_vec)) | rise;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      id_q    <= '0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      int_q   <= (state_d == REQ);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ack_vec = '0;
    unique case (state_q)
      IDLE: begin
        if (mie && (|eligible)) begin
          id_d    = win_id;
          state_d = REQ;
        end
      end
      REQ: begin
        // Ack takes precedence over withdrawal.
        if (cu.int_taken) begin
          ack_vec[id_q] = 1'b1;
          state_d       = ACK;
        end else if (!mie || !eligible[id_q]) begin
          state_d = IDLE;
        end
      end
      ACK: begin
        if (!cu.int_taken) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cu.INT    = int_q;
  assign cu.int_id = id_q;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

  localparam int unsigned N = 8;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic         CLK;
  logic         RST_N;
  logic [N-1:0] irq_src;
  logic         mie;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic [N-1:0] pend_clr;
  logic [N-1:0] pending;
  logic [N-1:0] mask;

  intr_ctrl_if #(.NUM_SRC(N)) bus ();

  intr_ctrl #(
    .NUM_SRC     (N),
    .SYNC_STAGES (2)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .irq_src    (irq_src),
    .mie        (mie),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .pend_clr   (pend_clr),
    .cu         (bus.master),
    .pending    (pending),
    .mask       (mask)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic push(input string tag, input logic [31:0] e);
    sb.push_back('{tag, e});
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0h required <none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) n_pass++;
      else $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N         = 1'b0;
    irq_src       = '0;
    mie           = 1'b0;
    mask_we       = 1'b0;
    mask_wdata    = '0;
    pend_clr      = '0;
    bus.int_taken = 1'b0;

    // Reset state
    tick(2);
    push("rst_int", 0);     chk(32'(bus.INT));
    push("rst_id", 0);      chk(32'(bus.int_id));
    push("rst_pending", 0); chk(32'(pending));
    push("rst_mask", 0);    chk(32'(mask));
    RST_N = 1'b1;
    tick(5);

    // Single source
    write_mask(8'h04);
    mie = 1'b1;
    push("s1_mask", 32'h04); chk(32'(mask));
    irq_src[2] = 1'b1;
    push("s1_pend_e0", 0); push("s1_pend_e1", 0);
    push("s1_pend_e2", 32'h04); push("s1_int_e2", 0);
    push("s1_int_e3", 1); push("s1_id_e3", 2);
    tick(); chk(32'(pending));
    tick(); chk(32'(pending));
    tick(); chk(32'(pending)); chk(32'(bus.INT));
    tick(); chk(32'(bus.INT)); chk(32'(bus.int_id));
    bus.int_taken = 1'b1;
    push("s1_ack_int", 0); push("s1_ack_pend", 0); push("s1_ack2_int", 0);
    tick(); chk(32'(bus.INT)); chk(32'(pending));
    tick(); chk(32'(bus.INT));
    bus.int_taken = 1'b0;
    push("s1_idle_int", 0);
    tick(2); chk(32'(bus.INT));
    irq_src = '0;
    tick(3);

    // Priority / freeze
    write_mask(8'hFF);
    irq_src[5] = 1'b1;
    push("pf_int5", 1); push("pf_id5", 5);
    tick(4); chk(32'(bus.INT)); chk(32'(bus.int_id));
    irq_src[1] = 1'b1;
    push("pf_pend", 32'h22); push("pf_int_frz", 1); push("pf_id_frz", 5);
    tick(3); chk(32'(pending)); chk(32'(bus.INT)); chk(32'(bus.int_id));
    bus.int_taken = 1'b1;
    push("pf_ack_pend", 32'h02);
    tick(); chk(32'(pending));
    tick();
    bus.int_taken = 1'b0;
    push("pf_fall1_int", 0); push("pf_re_int", 1); push("pf_re_id", 1);
    tick(); chk(32'(bus.INT));
    tick(); chk(32'(bus.INT)); chk(32'(bus.int_id));
    bus.int_taken = 1'b1;
    tick(2);
    bus.int_taken = 1'b0;
    irq_src = '0;
    push("pf_clean_pend", 0);
    tick(4); chk(32'(pending));

    // Masked latch
    write_mask(8'h00);
    irq_src[3] = 1'b1;
    tick();
    irq_src[3] = 1'b0;
    push("ml_pend", 32'h08); push("ml_int_off", 0);
    tick(4); chk(32'(pending)); chk(32'(bus.INT));
    mask_we    = 1'b1;
    mask_wdata = 8'h08;
    tick();
    mask_we    = 1'b0;
    push("ml_int_on", 1); push("ml_id", 3);
    tick(); chk(32'(bus.INT)); chk(32'(bus.int_id));

    // Withdrawal, then withdrawal vs. ack
    mie = 1'b0;
    push("wd_int", 0); push("wd_pend", 32'h08);
    tick(); chk(32'(bus.INT)); chk(32'(pending));
    mie = 1'b1;
    push("wd_rereq", 1);
    tick(); chk(32'(bus.INT));
    mie           = 1'b0;
    bus.int_taken = 1'b1;
    push("wa_int", 0); push("wa_pend", 0);
    tick(); chk(32'(bus.INT)); chk(32'(pending));
    tick();
    bus.int_taken = 1'b0;
    mie           = 1'b1;
    push("wa_idle_int", 0);
    tick(2); chk(32'(bus.INT));

    // Simultaneous set/clear on source 2
    write_mask(8'h04);
    irq_src[2] = 1'b1;
    push("sc_int", 1); push("sc_id", 2);
    tick(4); chk(32'(bus.INT)); chk(32'(bus.int_id));
    irq_src[2] = 1'b0;
    tick(2);
    irq_src[2] = 1'b1;
    tick(2);
    bus.int_taken = 1'b1;
    push("sc_ack_int", 0); push("sc_pend_kept", 32'h04);
    tick(); chk(32'(bus.INT)); chk(32'(pending));
    tick();
    bus.int_taken = 1'b0;
    push("sc_fall1_int", 0); push("sc_re_int", 1); push("sc_re_id", 2);
    tick(); chk(32'(bus.INT));
    tick(); chk(32'(bus.INT)); chk(32'(bus.int_id));
    bus.int_taken = 1'b1;
    push("sc_final_pend", 0);
    tick(); chk(32'(pending));
    tick();
    bus.int_taken = 1'b0;
    tick();

    // Async reset mid-REQ
    irq_src[2] = 1'b0;
    tick(3);
    irq_src[2] = 1'b1;
    push("ar_pre_int", 1);
    tick(4); chk(32'(bus.INT));
    #2;
    RST_N = 1'b0;
    #1;
    push("ar_int", 0); push("ar_pend", 0); push("ar_mask", 0); push("ar_id", 0);
    chk(32'(bus.INT)); chk(32'(pending)); chk(32'(mask)); chk(32'(bus.int_id));
    tick(2);
    RST_N = 1'b1;
    write_mask(8'hFF);
    push("ar_held_pend", 0); push("ar_held_int", 0);
    tick(8); chk(32'(pending)); chk(32'(bus.INT));
    irq_src[2] = 1'b0;
    tick(3);
    irq_src[2] = 1'b1;
    push("ar_new_int", 1); push("ar_new_id", 2);
    tick(4); chk(32'(bus.INT)); chk(32'(bus.int_id));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller driving the `INT` input of the multicycle CPU control unit and consuming its `intTaken` acknowledge. It owns the interrupt-controller end of the INT/intTaken protocol. It synchronizes external level sources and latches rising edges as pending. It presents one masked, fixed-priority request with a source ID and retires that request exactly once per trap entry.

## Interface
Parameters:
- `NUM_SRC`, 8, number of interrupt sources (2..32)
- `SYNC_STAGES`, 2, synchronizer flops per source (>=2)

Ports:
- `CLK` in 1: system clock
- `RST_N` in 1: asynchronous, active-low reset
- `irq_src` in NUM_SRC: asynchronous source levels; rising edge = event
- `mie` in 1: global enable from CSR (MIE bit)
- `mask_we` in 1: write strobe for enable mask
- `mask_wdata` in NUM_SRC: new enable mask
- `pend_clr` in NUM_SRC: software clear of pending bits, one-cycle pulses
- `int_taken` in 1: CU intTaken; high for 2 consecutive cycles per trap entry
- `INT` out 1: interrupt request to CU
- `int_id` out $clog2(NUM_SRC): index of requested source, valid while INT=1
- `pending` out NUM_SRC: pending register
- `mask` out NUM_SRC: enable-mask register

## Operation
- Per source: SYNC_STAGES-flop synchronizer, then `prev` flop; `rise = sync_out & ~prev`.
- Setting and clearing `pending[i]`:
  - set on `rise[i]`;
  - cleared on ack of i or `pend_clr[i]`;
  - a set and a clear in the same cycle leave the bit set.
- `mask` loads `mask_wdata` when `mask_we`=1. `mask` does not affect latching. Masked sources stay pending.
- `eligible = pending & mask`. Priority is fixed: the lowest index wins.
- FSM (all outputs registered):
  - IDLE:
    - INT=0.
    - If `mie` and `|eligible`: capture the winning index into `id_q`, then go to REQ.
  - REQ:
    - INT=1, `int_id=id_q`. `id_q` is frozen, even if a higher-priority source becomes pending.
    - If `int_taken`=1: clear `pending[id_q]` and go to ACK. This takes precedence over withdrawal.
    - Else if `mie`=0, or `eligible[id_q]`=0 (mask bit or pending cleared by software): withdraw and go to IDLE.
  - ACK:
    - INT=0.
    - Stay while `int_taken`=1. Go to IDLE on the first cycle with `int_taken`=0.
    - The second intTaken cycle therefore never acknowledges twice.
- `int_taken` seen in IDLE or ACK (spurious/late) is ignored; no pending bit changes.
- Reset (any time, mid-request included) values:
  - FSM state, sync/prev flops, `pending` and `mask`: IDLE / all 0;
  - outputs: INT=0, `int_id`=0.
  - After release, a source already high produces no event until it falls and rises again.

## Timing
- Source high before edge 0 (SYNC_STAGES=2):
  - sync out after edge 1;
  - `pending` set after edge 2;
  - INT=1 after edge 3.
  - General latency = SYNC_STAGES+1 edges to pending, +1 to INT.
- Ack:
  - `int_taken` rises at edge t: INT=0 and pending bit cleared after edge t.
  - Earliest next INT: 2 edges after `int_taken` falls (ACK→IDLE, then IDLE→REQ).
- Withdrawal: INT falls one edge after the cycle in which `mie` or `eligible[id_q]` is low.
- `mask_we` write takes effect for arbitration on the following cycle.

## Structure
- Package `intr_pkg`: state typedef `intr_state_t {IDLE, REQ, ACK}` and shared default constants.
- Sub-module `intr_sync_edge`, parameterized by width and stages: synchronizer + `prev` + `rise` vector. Instantiated once for all sources.
- Priority encoder and FSM live in `intr_ctrl`.

## Test plan
- **Single source:**
  - Stimulus: mask=8'h04, mie=1, raise irq_src[2].
  - Response: pending=8'h04 after edge 2, INT=1 and int_id=2 after edge 3.
  - Then a 2-cycle int_taken: INT=0 and pending=0 after first taken edge; no re-request during the second taken cycle.
- **Priority/freeze:**
  - Stimulus: mask=8'hFF, raise src 5; while INT=1 with id=5, raise src 1.
  - Response: id stays 5 until taken; 2 edges after taken falls, INT=1 with id=1.
- **Masked latch:**
  - Stimulus: mask=0, pulse src 3.
  - Response: pending=8'h08, INT stays 0; write mask=8'h08 → INT=1, id=3 within 2 edges.
- **Withdrawal vs. ack:**
  - Stimulus: in REQ, drop mie with int_taken=0.
  - Response: INT=0 next edge, pending kept.
  - Repeat with mie drop and int_taken=1 in the same cycle → ack wins, pending bit cleared.
- **Simultaneous set/clear:**
  - Stimulus: new rise on src 2 in the same cycle as its ack.
  - Response: pending[2] remains 1, INT re-asserts after ACK completes.
- **Async reset mid-REQ:**
  - Stimulus: assert RST_N=0 with no clock edge.
  - Response: INT=0, pending=0, mask=0 immediately; source held high across reset gives no request after release.
